// File: rtl/spi_log_pkg.sv
// spi_log_pkg -- shared definitions for the SPI log FIFO.
//   MARKER_DEFAULT : default escape / record lead byte
//   FRAME_CODE     : record code written at the end of an SPI transaction
//   DROP_MAX       : saturation value of the dropped-byte counter
//   ESC_CODE       : second byte of an escaped literal MARKER
//   enc_state_t    : UART-side encoder states
//   log_entry_t    : 9-bit FIFO entry (record flag + byte/code)
package spi_log_pkg;

    localparam logic [7:0] MARKER_DEFAULT = 8'hFF;
    localparam logic [7:0] FRAME_CODE     = 8'h80;
    localparam logic [6:0] DROP_MAX       = 7'd127;
    localparam logic [7:0] ESC_CODE       = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BYTE1 = 2'd2,
        BYTE2 = 2'd3
    } enc_state_t;

    typedef struct packed {
        logic       is_rec;  // 1: record, code holds the record code
        logic [7:0] code;    // log byte or record code
    } log_entry_t;

    // An entry needs a two-byte UART sequence when it is a record or a
    // literal byte that collides with the lead byte.
    function automatic logic needs_pair(input log_entry_t e, input logic [7:0] marker);
        return e.is_rec || (e.code == marker);
    endfunction

endpackage

// File: rtl/spi_log_ram.sv
// spi_log_ram -- simple dual-port DEPTH x 9 storage with synchronous read,
// written so that it maps onto a block RAM. Contents are never reset.
//   clk       : clock
//   wr_en     : write strobe, wr_addr / wr_data valid
//   rd_en     : read strobe, rd_data_q is updated on the next edge
//   rd_data_q : registered read data
module spi_log_ram
    import spi_log_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  log_entry_t    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output log_entry_t    rd_data_q
);

    log_entry_t mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_log_fifo.sv
// spi_log_fifo -- buffers SPI log bytes and forwards them to a UART with
// MARKER escaping, drop-count records and (optionally) end-of-frame records.
//   clk, reset           : clock, asynchronous active-low reset
//   log_strobe, log_val  : incoming log byte
//   spi_active           : SPI transaction in progress (frame records only)
//   txd_ready            : UART can take a byte this cycle
//   txd_strobe, txd_data : byte to the UART
//   fill_level           : occupied FIFO entries
//   overflow             : sticky, set on the first dropped byte
// Optional feature: define SPI_LOG_FRAME_EN to emit a frame record
// (MARKER, 8'h80) after each falling edge of spi_active.
module spi_log_fifo
    import spi_log_pkg::*;
#(
    parameter int         DEPTH  = 256,
    parameter logic [7:0] MARKER = MARKER_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     log_strobe,
    input  logic [7:0]               log_val,
    input  logic                     spi_active,
    input  logic                     txd_ready,
    output logic                     txd_strobe,
    output logic [7:0]               txd_data,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [6:0]    drop_cnt_q, drop_cnt_d, drop_base;
    logic          overflow_q, overflow_d;
    enc_state_t    state_q, state_d;
    log_entry_t    hold_q, hold_d, wr_entry, rd_data_q;
    logic [7:0]    txd_data_q, txd_data_d;
    logic          full, wr_drop, wr_frame, wr_log, log_lost, push, pop, rd_en;

`ifdef SPI_LOG_FRAME_EN
    logic spi_prev_q, spi_prev_d, frame_pending_q, frame_pending_d;
`else
    logic unused_spi_active;
    assign unused_spi_active = spi_active;
`endif

    spi_log_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk       (clk),
        .wr_en     (push),
        .wr_addr   (wr_ptr_q),
        .wr_data   (wr_entry),
        .rd_en     (rd_en),
        .rd_addr   (rd_ptr_q),
        .rd_data_q (rd_data_q)
    );

    // Write arbitration, drop accounting and frame tracking.
    always_comb begin
        full     = (fill_q == FULL_LVL);
        wr_drop  = (drop_cnt_q != 7'd0) && !full;
`ifdef SPI_LOG_FRAME_EN
        wr_frame = frame_pending_q && !full && !wr_drop;
        spi_prev_d = spi_active;
        // Edges arriving while a record is still pending merge into it.
        frame_pending_d = (frame_pending_q && !wr_frame) || (spi_prev_q && !spi_active);
`else
        wr_frame = 1'b0;
`endif
        wr_log   = log_strobe && !full && !wr_drop && !wr_frame;
        log_lost = log_strobe && !wr_log;
        push     = wr_drop || wr_frame || wr_log;

        if (wr_drop) begin
            wr_entry = '{is_rec: 1'b1, code: {1'b0, drop_cnt_q}};
        end else if (wr_frame) begin
            wr_entry = '{is_rec: 1'b1, code: FRAME_CODE};
        end else begin
            wr_entry = '{is_rec: 1'b0, code: log_val};
        end

        // A byte lost in the same cycle the record goes out starts a new count.
        drop_base = wr_drop ? 7'd0 : drop_cnt_q;
        if (log_lost) begin
            if (drop_base == DROP_MAX) begin
                drop_cnt_d = DROP_MAX;
            end else begin
                drop_cnt_d = drop_base + 7'd1;
            end
        end else begin
            drop_cnt_d = drop_base;
        end
        overflow_d = overflow_q || log_lost;
    end

    // Pointer and occupancy update; a pop only frees its slot next cycle.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Encoder: the entry stays counted in the FIFO until its last byte is sent.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        txd_data_d = txd_data_q;
        rd_en      = 1'b0;
        pop        = 1'b0;
        txd_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_q != '0) begin
                    rd_en   = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                hold_d     = rd_data_q;
                txd_data_d = needs_pair(rd_data_q, MARKER) ? MARKER : rd_data_q.code;
                state_d    = BYTE1;
            end
            BYTE1: begin
                if (txd_ready) begin
                    txd_strobe = 1'b1;
                    if (needs_pair(hold_q, MARKER)) begin
                        txd_data_d = hold_q.is_rec ? hold_q.code : ESC_CODE;
                        state_d    = BYTE2;
                    end else begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = BYTE1;
                end
            end
            BYTE2: begin
                if (txd_ready) begin
                    txd_strobe = 1'b1;
                    pop        = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = BYTE2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fill_q          <= '0;
            drop_cnt_q      <= 7'd0;
            overflow_q      <= 1'b0;
            state_q         <= IDLE;
            hold_q          <= '0;
            txd_data_q      <= 8'h00;
`ifdef SPI_LOG_FRAME_EN
            spi_prev_q      <= 1'b0;
            frame_pending_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fill_q          <= fill_d;
            drop_cnt_q      <= drop_cnt_d;
            overflow_q      <= overflow_d;
            state_q         <= state_d;
            hold_q          <= hold_d;
            txd_data_q      <= txd_data_d;
`ifdef SPI_LOG_FRAME_EN
            spi_prev_q      <= spi_prev_d;
            frame_pending_q <= frame_pending_d;
`endif
        end
    end

    assign txd_data   = txd_data_q;
    assign fill_level = fill_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_spi_log_fifo.sv
`timescale 1ns/1ps
module tb_spi_log_fifo;

    localparam int         DEPTH = 4;
    localparam int         FW    = $clog2(DEPTH) + 1;
    localparam logic [7:0] MK    = 8'hFF;

    logic          clk = 1'b0;
    logic          reset, log_strobe, spi_active, txd_ready, txd_strobe, overflow;
    logic [7:0]    log_val, txd_data;
    logic [FW-1:0] fill_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;   // 0: ready low, 1: ready high, 2: toggle, 3: odd cycles high, even random
    int strobe_cyc = 0;

    logic [7:0] out_q[$];
    int         out_cyc[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] val;
        int         n;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;
    vec_t tbl[6];

    spi_log_fifo #(.DEPTH(DEPTH), .MARKER(MK)) dut (
        .clk        (clk),
        .reset      (reset),
        .log_strobe (log_strobe),
        .log_val    (log_val),
        .spi_active (spi_active),
        .txd_ready  (txd_ready),
        .txd_strobe (txd_strobe),
        .txd_data   (txd_data),
        .fill_level (fill_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Output monitor: collect every UART byte and check the handshake.
    always @(negedge clk) begin
        if (reset && txd_strobe) begin
            total++;
            if (!txd_ready) begin
                bad++;
                $display("FAIL strobe_without_ready: txd_strobe=1 txd_ready=%0b at cycle %0d", txd_ready, cyc);
            end
            out_q.push_back(txd_data);
            out_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            0:       txd_ready = 1'b0;
            1:       txd_ready = 1'b1;
            2:       txd_ready = ~txd_ready;
            3:       txd_ready = (cyc % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            default: txd_ready = 1'b0;
        endcase
    endtask

    task automatic strobe(input logic [7:0] b);
        log_strobe = 1'b1;
        log_val    = b;
        strobe_cyc = cyc;
        tick();
        log_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (out_q.size() < n) begin
            bad++;
            $display("FAIL %s_timeout: got %0d bytes, expected %0d", name, out_q.size(), n);
        end
    endtask

    // Compare collected UART bytes against the expected stream, then clear both.
    task automatic check_stream(input string name);
        chk({name, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), 32'(out_q[i]), 32'(exp_q[i]));
        end
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    // Reference encoding of one literal log byte.
    function automatic void model_byte(input logic [7:0] b);
        if (b == MK) begin
            exp_q.push_back(MK);
            exp_q.push_back(8'h00);
        end else begin
            exp_q.push_back(b);
        end
    endfunction

    initial begin
        logic [7:0] b;
        reset = 1'b0; log_strobe = 1'b0; log_val = 8'h00; spi_active = 1'b0; txd_ready = 1'b0;

        tbl[0] = '{val: 8'h00, n: 1, e0: 8'h00, e1: 8'h00};
        tbl[1] = '{val: 8'hFF, n: 2, e0: 8'hFF, e1: 8'h00};
        tbl[2] = '{val: 8'hFE, n: 1, e0: 8'hFE, e1: 8'h00};
        tbl[3] = '{val: 8'h80, n: 1, e0: 8'h80, e1: 8'h00};
        tbl[4] = '{val: 8'h7F, n: 1, e0: 8'h7F, e1: 8'h00};
        tbl[5] = '{val: 8'h03, n: 1, e0: 8'h03, e1: 8'h00};

        // Reset state.
        #2;
        chk("rst_strobe", 32'(txd_strobe), 32'd0);
        chk("rst_data", 32'(txd_data), 32'h00);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        mode = 1;
        do_reset();

        // Plain byte plus escaped literal.
        strobe(8'h12);
        strobe(8'hFF);
        wait_out(3, 40, "basic");
        repeat (5) tick();
        chk("basic_latency_ok", 32'((out_cyc[0] - strobe_cyc + 1) >= 2), 32'd1);
        chk("basic_fill", 32'(fill_level), 32'd0);
        exp_q = '{8'h12, 8'hFF, 8'h00};
        check_stream("basic");

        // Table vectors with ready toggling.
        mode = 2;
        for (int i = 0; i < 6; i++) begin
            strobe(tbl[i].val);
            wait_out(tbl[i].n, 40, "tbl");
            repeat (4) tick();
            exp_q.push_back(tbl[i].e0);
            if (tbl[i].n == 2) exp_q.push_back(tbl[i].e1);
            check_stream($sformatf("tbl%0d", i));
        end

        // Overflow on a tiny FIFO, drop record of 3.
        mode = 0;
        do_reset();
        for (int i = 0; i < 7; i++) strobe(8'(8'h10 + i));
        repeat (3) tick();
        chk("ovf_fill", 32'(fill_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_quiet", 32'(out_q.size()), 32'd0);
        mode = 1;
        wait_out(6, 60, "ovf");
        repeat (5) tick();
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hFF, 8'h03};
        check_stream("ovf");
        strobe(8'h20);
        wait_out(1, 40, "ovf_next");
        repeat (3) tick();
        exp_q = '{8'h20};
        check_stream("ovf_next");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Drop counter saturation.
        mode = 0;
        do_reset();
        for (int i = 0; i < 204; i++) strobe(8'(i));
        mode = 1;
        wait_out(6, 60, "sat");
        repeat (5) tick();
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h7F};
        check_stream("sat");

        // Frame record after the end of an SPI transaction.
        mode = 1;
        do_reset();
        spi_active = 1'b1;
        tick();
        strobe(8'hAA);
        strobe(8'hBB);
        spi_active = 1'b0;
        tick();
`ifdef SPI_LOG_FRAME_EN
        exp_q = '{8'hAA, 8'hBB, 8'hFF, 8'h80};
`else
        exp_q = '{8'hAA, 8'hBB};
`endif
        wait_out(exp_q.size(), 60, "frame");
        repeat (20) tick();
        check_stream("frame");

        // Frame edges while full: held, and two edges merge into one record.
        mode = 0;
        do_reset();
        for (int i = 0; i < 4; i++) strobe(8'(8'h31 + i));
        tick();
        spi_active = 1'b1; tick();
        spi_active = 1'b0; tick();
        spi_active = 1'b1; tick();
        spi_active = 1'b0; tick();
        repeat (3) tick();
        chk("frame_full_fill", 32'(fill_level), 32'd4);
        mode = 1;
`ifdef SPI_LOG_FRAME_EN
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'hFF, 8'h80};
`else
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34};
`endif
        wait_out(exp_q.size(), 80, "frame_full");
        repeat (20) tick();
        check_stream("frame_full");

        // Reset between the two bytes of an escaped literal.
        mode = 0;
        do_reset();
        strobe(8'hFF);
        repeat (5) tick();
        mode = 1;
        tick();
        mode = 0;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_strobe", 32'(txd_strobe), 32'd0);
        chk("midrst_fill", 32'(fill_level), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        mode = 1;
        repeat (10) tick();
        strobe(8'h5A);
        wait_out(2, 40, "midrst");
        repeat (5) tick();
        exp_q = '{8'hFF, 8'h5A};
        check_stream("midrst");

        // Random bytes against the reference encoding, ready toggling / random.
        do_reset();
        mode = 2;
        for (int i = 0; i < 80; i++) begin
            if (i == 40) mode = 3;
            b = ($urandom_range(0, 3) == 0) ? MK : 8'($urandom);
            model_byte(b);
            strobe(b);
            repeat (8) tick();
        end
        wait_out(exp_q.size(), 400, "rand");
        repeat (10) tick();
        chk("rand_fill", 32'(fill_level), 32'd0);
        chk("rand_ovf", 32'(overflow), 32'd0);
        check_stream("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
